// File: rtl/rv32i_tb_pkg.sv
// rtl/rv32i_tb_pkg.sv - shared request/tag types and port count for the data memory arbiter
package rv32i_tb_pkg;

    localparam int ARB_NUM_PORTS = 2;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic valid;
        logic id;
        logic we;
    } arb_tag_t;

endpackage

// File: rtl/rv32i_arb_tag_pipe.sv
// rtl/rv32i_arb_tag_pipe.sv - fixed-depth tag shift register with synchronous clear, head stage exposed
module rv32i_arb_tag_pipe
    import rv32i_tb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  arb_tag_t tag_in,
    output arb_tag_t head
);

    arb_tag_t stage_q [DEPTH];

    // Load stage 0 every edge and advance each tag one stage; reset discards all in-flight tags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign head = stage_q[DEPTH-1];

endmodule

// File: rtl/rv32i_dmem_arbiter.sv
// rtl/rv32i_dmem_arbiter.sv - two-port data memory arbiter; RV32I_DMEM_ARB_RR_EN selects round-robin over fixed priority
module rv32i_dmem_arbiter
    import rv32i_tb_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        p0_req_i,
    input  logic        p0_we_i,
    input  logic [3:0]  p0_be_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_wdata_i,
    input  logic        p1_req_i,
    input  logic        p1_we_i,
    input  logic [3:0]  p1_be_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_wdata_i,
    output logic        p0_gnt_o,
    output logic        p1_gnt_o,
    output logic        p0_rvalid_o,
    output logic        p1_rvalid_o,
    output logic [31:0] p0_rdata_o,
    output logic [31:0] p1_rdata_o,
    output logic        p0_store_ack_o,
    output logic        p1_store_ack_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_store_valid_i,
    output logic        err_o
);

    localparam int CW = $clog2(MEM_LAT + 1);

    logic [ARB_NUM_PORTS-1:0] req;
    logic [ARB_NUM_PORTS-1:0] gnt;
    logic [ARB_NUM_PORTS-1:0] rvalid;
    logic [ARB_NUM_PORTS-1:0] sack;
    dmem_req_t                port_req [ARB_NUM_PORTS];
    dmem_req_t                sel_req;
    logic                     win_id;
    logic                     fav;
    arb_tag_t                 tag_in;
    arb_tag_t                 head;
    logic [CW-1:0]            supp_q;
    logic                     active;
    logic                     head_load;
    logic                     head_store;
    logic                     err_now;
    logic                     err_q;

    assign req         = {p1_req_i, p0_req_i};
    assign port_req[0] = {p0_we_i, p0_be_i, p0_addr_i, p0_wdata_i};
    assign port_req[1] = {p1_we_i, p1_be_i, p1_addr_i, p1_wdata_i};

`ifdef RV32I_DMEM_ARB_RR_EN
    logic prio_q;

    // After an accepted grant the other port becomes favoured; idle cycles keep the current favourite
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else if (gnt[0]) begin
            prio_q <= 1'b1;
        end else if (gnt[1]) begin
            prio_q <= 1'b0;
        end
    end

    assign fav = prio_q;
`else
    assign fav = 1'b0;
`endif

    // Pick the winner: favourite on contention, otherwise the lone requester; nothing leaves during reset
    always_comb begin
        gnt     = '0;
        win_id  = 1'b0;
        sel_req = '0;
        if (!rst_i && (req != '0)) begin
            win_id      = (&req) ? fav : req[1];
            gnt[win_id] = 1'b1;
            sel_req     = port_req[win_id];
        end
    end

    assign p0_gnt_o    = gnt[0];
    assign p1_gnt_o    = gnt[1];
    assign mem_req_o   = |gnt;
    assign mem_we_o    = sel_req.we;
    assign mem_be_o    = sel_req.be;
    assign mem_addr_o  = sel_req.addr;
    assign mem_wdata_o = sel_req.wdata;
    assign tag_in      = {mem_req_o, win_id, mem_we_o};

    rv32i_arb_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tag_in (tag_in),
        .head   (head)
    );

    // Responses from requests issued before a reset are still in the memory for MEM_LAT cycles; ignore that window
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            supp_q <= CW'(MEM_LAT);
        end else if (supp_q != '0) begin
            supp_q <= supp_q - CW'(1);
        end
    end

    assign active     = !rst_i && (supp_q == '0);
    assign head_load  = head.valid && !head.we;
    assign head_store = head.valid && head.we;

    // Route memory responses to the port named by the head tag and flag any mismatch against it
    always_comb begin
        rvalid  = '0;
        sack    = '0;
        err_now = 1'b0;
        if (active) begin
            rvalid[head.id] = head_load && mem_rvalid_i;
            sack[head.id]   = head_store && mem_store_valid_i;
            err_now         = (mem_rvalid_i != head_load) || (mem_store_valid_i != head_store);
        end
    end

    assign p0_rvalid_o    = rvalid[0];
    assign p1_rvalid_o    = rvalid[1];
    assign p0_rdata_o     = rvalid[0] ? mem_rdata_i : '0;
    assign p1_rdata_o     = rvalid[1] ? mem_rdata_i : '0;
    assign p0_store_ack_o = sack[0];
    assign p1_store_ack_o = sack[1];

    // Sticky error: remembered from the first offending cycle until reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (err_now) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q || err_now;

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// tb/tb_rv32i_dmem_arbiter.sv - randomized self-checking bench; RV32I_DMEM_ARB_RR_EN selects round-robin expectations
module tb_rv32i_dmem_arbiter;

    localparam int MEM_LAT = 2;
`ifdef RV32I_DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        int          due;
        bit          port;
        bit          we;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [3:0]  p0_be, p1_be;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_store_ack, p1_store_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid, mem_store_valid;
    logic [31:0] mem_rdata;
    logic        err;
    logic [67:0] resp_obs;

    logic        inj_rv;
    logic        fill_en;
    logic [7:0]  fill_idx;
    logic [31:0] fill_data;
    logic [31:0] mem [256];
    logic        rv_pipe [MEM_LAT];
    logic        sv_pipe [MEM_LAT];
    logic [31:0] rd_pipe [MEM_LAT];

    logic [31:0] ref_mem [256];
    exp_t        q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    rv32i_dmem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .p0_req_i          (p0_req),
        .p0_we_i           (p0_we),
        .p0_be_i           (p0_be),
        .p0_addr_i         (p0_addr),
        .p0_wdata_i        (p0_wdata),
        .p1_req_i          (p1_req),
        .p1_we_i           (p1_we),
        .p1_be_i           (p1_be),
        .p1_addr_i         (p1_addr),
        .p1_wdata_i        (p1_wdata),
        .p0_gnt_o          (p0_gnt),
        .p1_gnt_o          (p1_gnt),
        .p0_rvalid_o       (p0_rvalid),
        .p1_rvalid_o       (p1_rvalid),
        .p0_rdata_o        (p0_rdata),
        .p1_rdata_o        (p1_rdata),
        .p0_store_ack_o    (p0_store_ack),
        .p1_store_ack_o    (p1_store_ack),
        .mem_req_o         (mem_req),
        .mem_we_o          (mem_we),
        .mem_be_o          (mem_be),
        .mem_addr_o        (mem_addr),
        .mem_wdata_o       (mem_wdata),
        .mem_rvalid_i      (mem_rvalid),
        .mem_rdata_i       (mem_rdata),
        .mem_store_valid_i (mem_store_valid),
        .err_o             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign resp_obs = {p0_rvalid, p0_rdata, p0_store_ack, p1_rvalid, p1_rdata, p1_store_ack};

    // Memory environment: fixed MEM_LAT response pipe, byte-masked writes, backdoor fill; not reset by rst
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fill_en) begin
            mem[fill_idx] <= fill_data;
            for (int i = 0; i < MEM_LAT; i++) begin
                rv_pipe[i] <= 1'b0;
                sv_pipe[i] <= 1'b0;
                rd_pipe[i] <= '0;
            end
        end else begin
            rv_pipe[0] <= mem_req && !mem_we;
            sv_pipe[0] <= mem_req && mem_we;
            rd_pipe[0] <= mem[mem_addr[9:2]];
            for (int i = 1; i < MEM_LAT; i++) begin
                rv_pipe[i] <= rv_pipe[i-1];
                sv_pipe[i] <= sv_pipe[i-1];
                rd_pipe[i] <= rd_pipe[i-1];
            end
            if (mem_req && mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign mem_rvalid      = rv_pipe[MEM_LAT-1] | inj_rv;
    assign mem_store_valid = sv_pipe[MEM_LAT-1];
    assign mem_rdata       = rd_pipe[MEM_LAT-1];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        p0_req = 0; p0_we = 0; p0_be = '0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_be = '0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic backdoor(input int idx, input logic [31:0] d);
        fill_en   = 1'b1;
        fill_idx  = idx[7:0];
        fill_data = d;
        tick();
        fill_en   = 1'b0;
        ref_mem[idx] = d;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
    endtask

    // Reference: an accepted request completes MEM_LAT cycles later at its own port
    task automatic model_accept(input bit port, input bit we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   idx;
        idx    = int'(addr[9:2]);
        e.due  = cyc + MEM_LAT;
        e.port = port;
        e.we   = we;
        e.data = '0;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end else begin
            e.data = ref_mem[idx];
        end
        q.push_back(e);
    endtask

    task automatic pop_expected(output logic [67:0] ev);
        logic        r0, s0, r1, s1;
        logic [31:0] d0, d1;
        exp_t        e;
        r0 = 0; s0 = 0; r1 = 0; s1 = 0; d0 = '0; d1 = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.port == 1'b0) begin
                r0 = !e.we; s0 = e.we; d0 = e.we ? 32'h0 : e.data;
            end else begin
                r1 = !e.we; s1 = e.we; d1 = e.we ? 32'h0 : e.data;
            end
        end
        ev = {r0, d0, s0, r1, d1, s1};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        p0_req = 1; p0_we = 1; p0_be = 4'hF; p0_addr = 32'h44; p0_wdata = $urandom;
        p1_req = 1; p1_we = 0; p1_be = 4'h3; p1_addr = 32'h88; p1_wdata = $urandom;
        inj_rv = 1'b1;
        @(negedge clk);
        total++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin
            bad++; $display("FAIL reset_gnt got=%b exp=00", {p0_gnt, p1_gnt});
        end
        total++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'd0) begin
            bad++; $display("FAIL reset_mem got=%h exp=0", {mem_req, mem_we, mem_be, mem_addr, mem_wdata});
        end
        total++;
        if (resp_obs !== 68'd0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_resp got=%h err=%b exp=0", resp_obs, err);
        end
        tick();
        inj_rv = 1'b0;
        idle_inputs();
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_single_load;
        logic [67:0] ev;
        backdoor(32'h10, 32'hDEADBEEF);
        p0_req = 1; p0_we = 0; p0_addr = 32'h40;
        @(negedge clk);
        total++;
        if ({p0_gnt, p1_gnt, mem_req, mem_addr} !== {1'b1, 1'b0, 1'b1, 32'h40}) begin
            bad++; $display("FAIL single_gnt got=%b%b%b %h exp=1011 00000040", p0_gnt, p1_gnt, mem_req, mem_addr);
        end
        model_accept(0, 0, 4'h0, 32'h40, 32'h0);
        tick();
        p0_req = 0;
        for (int i = 1; i <= MEM_LAT; i++) begin
            @(negedge clk);
            pop_expected(ev);
            total++;
            if (resp_obs !== ev) begin
                bad++; $display("FAIL single_resp edge=%0d got=%h exp=%h", i, resp_obs, ev);
            end
            if (i == MEM_LAT) begin
                total++;
                if ({p0_rvalid, p0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
                    bad++; $display("FAIL single_data got=%b %h exp=1 deadbeef", p0_rvalid, p0_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_contention;
        int          n0, n1;
        bit          g1;
        logic [67:0] ev;
        logic [31:0] a0, a1;
        n0 = 0; n1 = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            a0 = 32'h100 + 32'(8 * n0);
            a1 = 32'h300 + 32'(8 * n1);
            p0_req = (i < 6); p0_we = 0; p0_addr = a0;
            p1_req = 1;       p1_we = 0; p1_addr = a1;
            @(negedge clk);
            g1 = (i == 6) ? 1'b1 : (RR ? 1'(i % 2) : 1'b0);
            total++;
            if ({p1_gnt, p0_gnt} !== {g1, ~g1}) begin
                bad++; $display("FAIL contention_gnt cycle=%0d got=%b%b exp=%b%b", i, p1_gnt, p0_gnt, g1, ~g1);
            end
            pop_expected(ev);
            total++;
            if (resp_obs !== ev) begin
                bad++; $display("FAIL contention_resp cycle=%0d got=%h exp=%h", i, resp_obs, ev);
            end
            if (g1) begin
                model_accept(1, 0, 4'h0, a1, 32'h0); n1++;
            end else begin
                model_accept(0, 0, 4'h0, a0, 32'h0); n0++;
            end
            tick();
        end
        idle_inputs();
        for (int j = 0; j <= MEM_LAT; j++) begin
            @(negedge clk);
            pop_expected(ev);
            total++;
            if (resp_obs !== ev) begin
                bad++; $display("FAIL contention_drain j=%0d got=%h exp=%h", j, resp_obs, ev);
            end
            tick();
        end
        total++;
        if (err !== 1'b0 || q.size() != 0) begin
            bad++; $display("FAIL contention_err got=%b pending=%0d exp=0 0", err, q.size());
        end
    endtask

    task automatic test_store;
        logic [67:0] ev;
        logic [31:0] got;
        int          acks;
        acks = 0;
        got  = '0;
        backdoor(32'h20, 32'hFFFFFFFF);
        p1_req = 1; p1_we = 1; p1_be = 4'b0011; p1_addr = 32'h80; p1_wdata = 32'h1234ABCD;
        @(negedge clk);
        total++;
        if ({p1_gnt, p0_gnt, mem_we, mem_be, mem_wdata} !== {1'b1, 1'b0, 1'b1, 4'b0011, 32'h1234ABCD}) begin
            bad++; $display("FAIL store_gnt got=%b%b%b %b %h exp=101 0011 1234abcd", p1_gnt, p0_gnt, mem_we, mem_be, mem_wdata);
        end
        model_accept(1, 1, 4'b0011, 32'h80, 32'h1234ABCD);
        tick();
        idle_inputs();
        p0_req = 1; p0_we = 0; p0_addr = 32'h80;
        for (int j = 0; j <= MEM_LAT + 1; j++) begin
            @(negedge clk);
            if (j == 0) begin
                total++;
                if (p0_gnt !== 1'b1) begin
                    bad++; $display("FAIL store_load_gnt got=%b exp=1", p0_gnt);
                end
                model_accept(0, 0, 4'h0, 32'h80, 32'h0);
            end
            pop_expected(ev);
            total++;
            if (resp_obs !== ev) begin
                bad++; $display("FAIL store_resp j=%0d got=%h exp=%h", j, resp_obs, ev);
            end
            if (p1_store_ack) acks++;
            if (p0_rvalid) got = p0_rdata;
            tick();
            p0_req = 0;
        end
        total++;
        if (acks != 1) begin
            bad++; $display("FAIL store_ack got=%0d exp=1", acks);
        end
        total++;
        if (got !== 32'hFFFFABCD) begin
            bad++; $display("FAIL store_merge got=%h exp=ffffabcd", got);
        end
    endtask

    task automatic test_protocol_error;
        idle_inputs();
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL err_pre got=%b exp=0", err);
        end
        tick();
        inj_rv = 1'b1;
        @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL err_rise got=%b exp=1", err);
        end
        total++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            bad++; $display("FAIL err_unrouted got=%b exp=00", {p0_rvalid, p1_rvalid});
        end
        tick();
        inj_rv = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL err_hold got=%b exp=1", err);
        end
        rst = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL err_clear got=%b exp=0", err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_midflight;
        logic [67:0] ev;
        p0_req = 1; p0_we = 0; p0_addr = 32'h40;
        @(negedge clk);
        total++;
        if (p0_gnt !== 1'b1) begin
            bad++; $display("FAIL midflight_gnt got=%b exp=1", p0_gnt);
        end
        tick();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (p0_rvalid !== 1'b0) begin
            bad++; $display("FAIL midflight_rst_rvalid got=%b exp=0", p0_rvalid);
        end
        tick();
        rst = 1'b0;
        q.delete();
        p0_req = 1; p0_we = 0; p0_addr = 32'h44;
        for (int j = 0; j <= MEM_LAT + 1; j++) begin
            @(negedge clk);
            if (j == 0) model_accept(0, 0, 4'h0, 32'h44, 32'h0);
            pop_expected(ev);
            total++;
            if (resp_obs !== ev || err !== 1'b0) begin
                bad++; $display("FAIL midflight_resp j=%0d got=%h err=%b exp=%h err=0", j, resp_obs, err, ev);
            end
            tick();
            p0_req = 0;
        end
    endtask

    task automatic test_random_traffic;
        bit          pend [2];
        bit          pwe [2];
        logic [3:0]  pbe [2];
        logic [31:0] paddr [2];
        logic [31:0] pwd [2];
        bit          prio;
        bit          w;
        logic [67:0] ev;
        do_reset();
        prio = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; pwe[p] = 0; pbe[p] = '0; paddr[p] = '0; pwd[p] = '0;
        end
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 99) < 60) begin
                    pend[p]  = 1;
                    pwe[p]   = 1'($urandom_range(0, 1));
                    pbe[p]   = 4'($urandom);
                    paddr[p] = {22'd0, 8'($urandom), 2'b00};
                    pwd[p]   = $urandom;
                end
            end
            p0_req = pend[0]; p0_we = pwe[0]; p0_be = pbe[0]; p0_addr = paddr[0]; p0_wdata = pwd[0];
            p1_req = pend[1]; p1_we = pwe[1]; p1_be = pbe[1]; p1_addr = paddr[1]; p1_wdata = pwd[1];
            @(negedge clk);
            w = (pend[0] && pend[1]) ? (RR ? prio : 1'b0) : pend[1];
            total++;
            if ({p1_gnt, p0_gnt} !== {pend[1] & w, pend[0] & ~w}) begin
                bad++; $display("FAIL rnd_gnt cycle=%0d got=%b%b exp=%b%b", c, p1_gnt, p0_gnt, pend[1] & w, pend[0] & ~w);
            end
            pop_expected(ev);
            total++;
            if (resp_obs !== ev) begin
                bad++; $display("FAIL rnd_resp cycle=%0d got=%h exp=%h", c, resp_obs, ev);
            end
            if (pend[0] || pend[1]) begin
                total++;
                if ({mem_req, mem_we, mem_addr} !== {1'b1, pwe[w], paddr[w]} ||
                    (pwe[w] && {mem_be, mem_wdata} !== {pbe[w], pwd[w]})) begin
                    bad++; $display("FAIL rnd_mux cycle=%0d got=%b %h %h %h exp=%b %h %h %h", c, mem_we, mem_be, mem_addr, mem_wdata, pwe[w], pbe[w], paddr[w], pwd[w]);
                end
                model_accept(w, pwe[w], pbe[w], paddr[w], pwd[w]);
                pend[w] = 0;
                prio    = ~w;
            end
            tick();
        end
        idle_inputs();
        for (int j = 0; j <= MEM_LAT; j++) begin
            @(negedge clk);
            pop_expected(ev);
            total++;
            if (resp_obs !== ev) begin
                bad++; $display("FAIL rnd_drain j=%0d got=%h exp=%h", j, resp_obs, ev);
            end
            tick();
        end
        total++;
        if (err !== 1'b0 || q.size() != 0) begin
            bad++; $display("FAIL rnd_err got=%b pending=%0d exp=0 0", err, q.size());
        end
    endtask

    initial begin
        rst     = 1'b1;
        inj_rv  = 1'b0;
        fill_en = 1'b0;
        fill_idx  = '0;
        fill_data = '0;
        idle_inputs();
        for (int i = 0; i < 256; i++) begin
            backdoor(i, $urandom);
        end
        test_reset();
        test_single_load();
        test_contention();
        test_store();
        test_protocol_error();
        test_reset_midflight();
        test_random_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_dmem_arbiter.md
# rv32i_dmem_arbiter

Two-port arbiter that shares the single bench data memory model between the core load/store port (port 0) and a testbench side-channel requester such as a preload or debug port (port 1). Each cycle it grants at most one request, forwards it combinationally to the memory request interface, and tags it in a fixed-latency pipeline. Returning load data and store commit events are then routed back to the port that issued them. A sticky error flag reports any response that arrives out of step with the tag pipeline.

## Interface
- MEM_LAT, 2: cycles from an accepted request (the edge where mem_req_o is sampled) to its mem_rvalid_i / mem_store_valid_i; legal range 1–8.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- p0_req_i, p1_req_i  in  1  request; held high with stable fields until granted.
- p0_we_i, p1_we_i  in  1  1 = store, 0 = load.
- p0_be_i, p1_be_i  in  4  store byte enables.
- p0_addr_i, p1_addr_i  in  32  word-aligned byte address.
- p0_wdata_i, p1_wdata_i  in  32  store data.
- p0_gnt_o, p1_gnt_o  out  1  grant; the request is accepted at the edge where req and gnt are both high.
- p0_rvalid_o, p1_rvalid_o  out  1  load response valid, one cycle.
- p0_rdata_o, p1_rdata_o  out  32  load data, valid only with rvalid.
- p0_store_ack_o, p1_store_ack_o  out  1  store committed, one cycle.
- mem_req_o, mem_we_o  out  1  request to the memory.
- mem_be_o  out  4  byte enables to the memory.
- mem_addr_o, mem_wdata_o  out  32  address and write data to the memory.
- mem_rvalid_i  in  1  load response from the memory.
- mem_rdata_i  in  32  load data from the memory.
- mem_store_valid_i  in  1  store commit event from the memory.
- err_o  out  1  sticky protocol error.

## Operation
- Grant logic is combinational from the current requests and the priority state.
- At most one gnt is high per cycle. gnt is never high without the matching req.
- mem_req_o is high when either port requests. mem_we/be/addr/wdata_o are a mux of the winning port's fields. When neither port requests, the fields are driven to 0.
- Priority state `prio_q` names the favoured port; it applies only when both ports request.
  - A lone requester is always granted in the same cycle.
  - Round-robin mode: after an accepted grant to port k, `prio_q` becomes the other port. With no grant, `prio_q` holds.
  - Fixed mode: port 0 always wins.
- Tag pipeline: a MEM_LAT-stage shift register of {valid, id, we}. Stage 0 is loaded on every edge with {mem_req_o, winner id, mem_we_o}. Each stage shifts one stage per edge.
- The head stage (MEM_LAT-1) is matched against the memory responses in the same cycle they arrive:
  - Head valid with we=0: expect mem_rvalid_i. Drive p<id>_rvalid_o = mem_rvalid_i. Route mem_rdata_i to p<id>_rdata_o.
  - Head valid with we=1: expect mem_store_valid_i. Drive p<id>_store_ack_o.
  - rdata to the non-addressed port is driven to 0.
- err_o is set and held until reset on any of:
  - mem_rvalid_i with the head not a valid load;
  - mem_store_valid_i with the head not a valid store;
  - the head a valid load or store whose expected response is absent.
- Responses are always delivered, even when err_o sets. Nothing is dropped silently except after reset (below).

## Timing
- Reset values:
  - all gnt, rvalid, store_ack and err_o are 0; rdata is 0;
  - mem_* are 0 while rst_i is high (requests are masked during reset);
  - `prio_q` is port 0; all tag stages are invalid.
- Reset mid-operation: in-flight tags are discarded. Memory responses arriving within MEM_LAT cycles after reset release are ignored: not routed, and they do not set err_o. A suppress counter loaded with MEM_LAT at reset implements this.
- Throughput is one accepted request per cycle. There is no backpressure on responses.
- Back-to-back grants: a port requesting continuously against an idle competitor is granted every cycle.
- Both ports requesting continuously in round-robin mode: grants alternate 0,1,0,1 starting from `prio_q`.
- Load latency seen by a port equals MEM_LAT edges after acceptance.

## Configuration
- RV32I_DMEM_ARB_RR_EN defined: round-robin priority, `prio_q` register present.
- RV32I_DMEM_ARB_RR_EN undefined: fixed priority with port 0 highest; no `prio_q` register; port 1 may starve.

## Structure
- rv32i_tb_pkg holds:
  - `dmem_req_t`, a packed struct {we, be[3:0], addr[31:0], wdata[31:0]};
  - `arb_tag_t`, a packed struct {valid, id, we};
  - the constant `ARB_NUM_PORTS = 2`.
- One sub-module, rv32i_arb_tag_pipe: the MEM_LAT-deep tag shift register with synchronous clear, exposing its head stage.

## Test plan
- Single load: p0 load at 0x40 with mem[0x10]=0xDEADBEEF → p0_gnt same cycle; p0_rvalid and rdata=0xDEADBEEF 2 edges later; p1 outputs stay 0.
- Contention (RR defined): both ports load every cycle for 6 cycles → grants 0,1,0,1,0,1; responses return in the same interleaved order to the correct ports; err_o stays 0.
- Contention (RR undefined): same stimulus → p0 granted all 6 cycles, p1_gnt stays 0; p1 is granted in the first cycle p0 drops its request.
- Store: p1 store with be=4'b0011, wdata=0x1234ABCD to 0x80 (old word 0xFFFFFFFF) → p1_store_ack after 2 edges; a subsequent p0 load of 0x80 returns 0xFFFFABCD.
- Protocol error: inject mem_rvalid_i with no request in flight → err_o rises the same cycle and holds until rst_i.
- Reset mid-flight: issue a p0 load, assert rst_i for 1 cycle before its response → no p0_rvalid, err_o stays 0, and the next load after release completes normally.
